// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings,
// per-mode entry patterns, default board clock and the entry-value lookup.
package led_pattern_sequencer_pkg;

   localparam int unsigned DEFAULT_CLK_HZ = 25_000_000;

   typedef enum logic [1:0] {
      MODE_BINARY   = 2'd0,
      MODE_CHASE    = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_ALL      = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [3:0] ENTRY_BINARY   = 4'b0000;
   localparam logic [3:0] ENTRY_CHASE    = 4'b0001;
   localparam logic [3:0] ENTRY_PINGPONG = 4'b0001;
   localparam logic [3:0] ENTRY_ALL      = 4'b0000;

   // Pattern loaded when a mode is entered
   function automatic logic [3:0] entry_value(input mode_t m);
      logic [3:0] v;
      case (m)
         MODE_BINARY:   v = ENTRY_BINARY;
         MODE_CHASE:    v = ENTRY_CHASE;
         MODE_PINGPONG: v = ENTRY_PINGPONG;
         default:       v = ENTRY_ALL;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// tick_prescaler: divides clk by DIV and emits a registered one-cycle tick.
// en freezes the count, clr restarts it from zero and cancels a pending tick.
module tick_prescaler #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned CNT_W = 23
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   // Count 0..DIV-1; tick is high for the cycle after the count hits DIV-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (clr) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (en) begin
         if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: owns the four board LEDs and animates them through
// BINARY / CHASE / PINGPONG / ALL patterns at STEP_HZ. A mode_btn rising edge
// advances the mode; run=0 freezes the animation.
// Optional macro LED_PWM_EN adds a 4-bit brightness input that PWM-dims the LEDs.
module led_pattern_sequencer
   import led_pattern_sequencer_pkg::*;
#(
   parameter int unsigned CLK_HZ  = DEFAULT_CLK_HZ,
   parameter int unsigned STEP_HZ = 4,
   parameter int unsigned CNT_W   = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       mode_btn,
`ifdef LED_PWM_EN
   input  logic [3:0] brightness,
`endif
   output logic [1:0] mode,
   output logic       step_tick,
   output logic       led1,
   output logic       led2,
   output logic       led3,
   output logic       led4
);

   localparam int unsigned DIV = CLK_HZ / STEP_HZ;

   mode_t      r_mode,    w_mode_next;
   dir_t       r_dir,     w_dir_next;
   logic [3:0] r_pattern, w_pattern_next;
   logic       r_btn_q;
   logic       w_mode_req;
   logic       w_tick;

   // A request is the first cycle the button is seen high
   assign w_mode_req = mode_btn & ~r_btn_q;

   tick_prescaler #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (run),
      .clr  (w_mode_req),
      .tick (w_tick)
   );

   // Mode, pattern, direction and button-history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode    <= MODE_BINARY;
         r_dir     <= DIR_UP;
         r_pattern <= 4'b0000;
         r_btn_q   <= 1'b0;
      end else begin
         r_mode    <= w_mode_next;
         r_dir     <= w_dir_next;
         r_pattern <= w_pattern_next;
         r_btn_q   <= mode_btn;
      end
   end

   // Next mode/pattern: a mode request beats a coincident step tick
   always_comb begin
      w_mode_next    = r_mode;
      w_dir_next     = r_dir;
      w_pattern_next = r_pattern;
      if (w_mode_req) begin
         w_mode_next    = mode_t'(2'(r_mode + 2'd1));
         w_pattern_next = entry_value(w_mode_next);
         w_dir_next     = DIR_UP;
      end else if (w_tick) begin
         case (r_mode)
            MODE_BINARY: begin
               w_pattern_next = r_pattern + 4'd1;
            end
            MODE_CHASE: begin
               if (r_pattern == 4'b0000) w_pattern_next = 4'b0001;
               else                      w_pattern_next = {r_pattern[2:0], r_pattern[3]};
            end
            MODE_PINGPONG: begin
               if (r_pattern == 4'b0000) begin
                  w_pattern_next = 4'b0001;
                  w_dir_next     = DIR_UP;
               end else if (r_dir == DIR_UP) begin
                  if (r_pattern == 4'b1000) begin
                     w_pattern_next = 4'b0100;
                     w_dir_next     = DIR_DOWN;
                  end else begin
                     w_pattern_next = {r_pattern[2:0], 1'b0};
                  end
               end else begin
                  if (r_pattern == 4'b0001) begin
                     w_pattern_next = 4'b0010;
                     w_dir_next     = DIR_UP;
                  end else begin
                     w_pattern_next = {1'b0, r_pattern[3:1]};
                  end
               end
            end
            default: begin
               w_pattern_next = ~r_pattern;
            end
         endcase
      end
   end

`ifdef LED_PWM_EN
   logic [3:0] r_pwm_cnt;
   logic [3:0] r_led;

   // Free-running PWM phase and dimmed LED register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm_cnt <= 4'd0;
         r_led     <= 4'b0000;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
         r_led     <= r_pattern & {4{r_pwm_cnt < brightness}};
      end
   end

   assign {led4, led3, led2, led1} = r_led;
`else
   assign {led4, led3, led2, led1} = r_pattern;
`endif

   assign mode      = r_mode;
   assign step_tick = w_tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (DIV = 4, 40 ns clock).
module tb_led_pattern_sequencer;

   localparam int unsigned CLK_HZ  = 8;
   localparam int unsigned STEP_HZ = 2;
   localparam int unsigned DIV     = CLK_HZ / STEP_HZ;
   localparam int unsigned CNT_W   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       mode_btn;
   logic [1:0] mode;
   logic       step_tick;
   logic       led1, led2, led3, led4;
   logic [3:0] leds;
`ifdef LED_PWM_EN
   logic [3:0] brightness;
`endif

   always #20 clk = ~clk;

   led_pattern_sequencer #(
      .CLK_HZ  (CLK_HZ),
      .STEP_HZ (STEP_HZ),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .mode_btn   (mode_btn),
`ifdef LED_PWM_EN
      .brightness (brightness),
`endif
      .mode       (mode),
      .step_tick  (step_tick),
      .led1       (led1),
      .led2       (led2),
      .led3       (led3),
      .led4       (led4)
   );

   assign leds = {led4, led3, led2, led1};

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pattern as an integer, ping-pong as a phase in a 6-step cycle
   int m_mode, m_pat, m_pp_idx, m_cnt, m_tick, m_btn_q, m_pwm, m_led;
   int pp_seq[6] = '{1, 2, 4, 8, 4, 2};

   function automatic int entry(input int md);
      return (md == 1 || md == 2) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pat = 0; m_pp_idx = 0; m_cnt = 0;
      m_tick = 0; m_btn_q = 0; m_pwm = 0; m_led = 0;
   endtask

   task automatic model_edge();
      int pat_old, pwm_old;
      bit req;
      if (rst) begin
         model_reset();
         return;
      end
      pat_old = m_pat;
      pwm_old = m_pwm;
      req     = (mode_btn == 1'b1) && (m_btn_q == 0);
      m_btn_q = int'(mode_btn);
      if (req) begin
         m_mode   = (m_mode + 1) % 4;
         m_pat    = entry(m_mode);
         m_pp_idx = 0;
         m_cnt    = 0;
         m_tick   = 0;
      end else begin
         if (m_tick != 0) begin
            case (m_mode)
               0: m_pat = (m_pat + 1) % 16;
               1: m_pat = (m_pat == 0) ? 1 : ((m_pat * 2) % 16 + m_pat / 8);
               2: begin
                  m_pp_idx = (m_pp_idx + 1) % 6;
                  m_pat    = pp_seq[m_pp_idx];
               end
               default: m_pat = 15 - m_pat;
            endcase
         end
         if (run) begin
            if (m_cnt == int'(DIV) - 1) begin
               m_cnt  = 0;
               m_tick = 1;
            end else begin
               m_cnt  = m_cnt + 1;
               m_tick = 0;
            end
         end else begin
            m_tick = 0;
         end
      end
`ifdef LED_PWM_EN
      m_led = (pwm_old < int'(brightness)) ? pat_old : 0;
      m_pwm = (m_pwm + 1) % 16;
`else
      m_led = m_pat;
`endif
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("leds_vs_model", 32'(leds), 32'(m_led));
      check("mode_vs_model", 32'(mode), 32'(m_mode));
      check("tick_vs_model", 32'(step_tick), 32'(m_tick));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_tick(input int max_cyc, output int waited);
      waited = 0;
      do begin
         cycle();
         waited++;
      end while (step_tick !== 1'b1 && waited < max_cyc);
      check("tick_arrival", 32'(step_tick), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   typedef struct {
      logic       run;
      logic       btn;
      int         n;
      logic [1:0] exp_mode;
      logic [3:0] exp_led;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int on_cnt;
      logic [3:0] held;

      vecs[0] = '{1'b0, 1'b1, 10, 2'd1, 4'b0001};
      vecs[1] = '{1'b0, 1'b0,  2, 2'd1, 4'b0001};
      vecs[2] = '{1'b0, 1'b1, 10, 2'd2, 4'b0001};
      vecs[3] = '{1'b0, 1'b0,  2, 2'd2, 4'b0001};
      vecs[4] = '{1'b0, 1'b1, 10, 2'd3, 4'b0000};
      vecs[5] = '{1'b0, 1'b0,  2, 2'd3, 4'b0000};
      vecs[6] = '{1'b0, 1'b1, 10, 2'd0, 4'b0000};
      vecs[7] = '{1'b0, 1'b0,  2, 2'd0, 4'b0000};

      rst = 1'b0; run = 1'b1; mode_btn = 1'b0;
`ifdef LED_PWM_EN
      brightness = 4'd15;
`endif
      // Reset state, checked before any clock edge
      #3 rst = 1'b1;
      #2;
      model_reset();
      check("reset_leds", 32'(leds), 32'd0);
      check("reset_mode", 32'(mode), 32'd0);
      check("reset_tick", 32'(step_tick), 32'd0);
      cycles(2);
      rst = 1'b0;

      // BINARY counting with 4-cycle tick period and wrap
      wait_tick(10, w);
      check("first_tick_latency", 32'(w), 32'd4);
      for (int k = 1; k <= 16; k++) begin
         cycle();
`ifndef LED_PWM_EN
         check("binary_leds", 32'(leds), 32'(k % 16));
`endif
         wait_tick(8, w);
         check("tick_period", 32'(w + 1), 32'(DIV));
      end

      // Mode presses held high: one advance per press, entry values loaded
      do_reset();
      foreach (vecs[i]) begin
         run      = vecs[i].run;
         mode_btn = vecs[i].btn;
         cycles(vecs[i].n);
         check("table_mode", 32'(mode), 32'(vecs[i].exp_mode));
`ifndef LED_PWM_EN
         check("table_leds", 32'(leds), 32'(vecs[i].exp_led));
`endif
         check("table_tick", 32'(step_tick), 32'd0);
      end

      // PINGPONG sequence over 12 steps
      mode_btn = 1'b1; cycle();
      mode_btn = 1'b0; cycle();
      mode_btn = 1'b1; cycle();
      mode_btn = 1'b0;
      check("pingpong_mode", 32'(mode), 32'd2);
      run = 1'b1;
      for (int k = 0; k < 12; k++) begin
         logic [3:0] exp_pp [6];
         exp_pp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
         wait_tick(8, w);
         cycle();
`ifndef LED_PWM_EN
         check("pingpong_leds", 32'(leds), 32'(exp_pp[k % 6]));
`endif
      end

      // Freeze mid-count: resume finishes the remaining count only
      wait_tick(8, w);
      cycles(2);
      run  = 1'b0;
      held = leds;
      cycles(20);
`ifndef LED_PWM_EN
      check("frozen_leds", 32'(leds), 32'(held));
`endif
      run = 1'b1;
      wait_tick(8, w);
      check("resume_latency", 32'(w), 32'd2);

      // Mode request coinciding with a tick: no step, cleared prescaler
      wait_tick(8, w);
      mode_btn = 1'b1;
      cycle();
      mode_btn = 1'b0;
      check("coincide_mode", 32'(mode), 32'd3);
`ifndef LED_PWM_EN
      check("coincide_leds", 32'(leds), 32'd0);
`endif
      check("coincide_tick", 32'(step_tick), 32'd0);
      wait_tick(8, w);
      check("coincide_next_tick", 32'(w), 32'(DIV));

      // Asynchronous reset between edges while in CHASE
      mode_btn = 1'b1; cycle();
      mode_btn = 1'b0; cycle();
      mode_btn = 1'b1; cycle();
      mode_btn = 1'b0;
      cycles(9);
      check("chase_mode", 32'(mode), 32'd1);
      @(posedge clk);
      model_edge();
      #10 rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_leds", 32'(leds), 32'd0);
      check("async_rst_mode", 32'(mode), 32'd0);
      check("async_rst_tick", 32'(step_tick), 32'd0);
      cycles(2);
      rst = 1'b0;

`ifdef LED_PWM_EN
      // PWM duty: brightness 4 lights each LED 4 of every 16 cycles
      brightness = 4'd4;
      for (int p = 0; p < 3; p++) begin
         mode_btn = 1'b1; cycle();
         mode_btn = 1'b0; cycle();
      end
      wait_tick(8, w);
      cycle();
      run = 1'b0;
      cycles(2);
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
         cycle();
         on_cnt += int'(led1) + int'(led2) + int'(led3) + int'(led4);
      end
      check("pwm_on_count", 32'(on_cnt), 32'd16);
      run = 1'b1;
`else
      on_cnt = 0;
`endif

      // Randomised run/button/brightness traffic against the model
      for (int c = 0; c < 600; c++) begin
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) mode_btn = ~mode_btn;
`ifdef LED_PWM_EN
         if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
`endif
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
